// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 8-bit ALU between two requesters
//
// alu: combinational 8-bit ALU.
//   a, b      : operands
//   op        : 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr
//               (shift distance is b[2:0]); 111 yields 0
//   result    : 8-bit result
//   zero      : result == 0
//   overflow  : signed overflow for add/sub, 0 otherwise
//
// alu_arbiter: accepts one request at a time from two requesters, runs it
// through the ALU and holds the registered response until consumed.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester request handshake (bit i = requester i)
//   req_a*/req_b*/req_op* : requester operands and opcodes
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id                : requester that issued the returned operation
//   rsp_result/zero/overflow/err : registered ALU outputs, err = illegal opcode
//   busy                  : not idle
//   ops_count             : completed responses, saturating

module alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] result,
  output logic       zero,
  output logic       overflow
);
  always_comb begin
    result   = 8'h00;
    overflow = 1'b0;
    case (op)
      3'b000: begin
        result   = a + b;
        overflow = (a[7] == b[7]) && (result[7] != a[7]);
      end
      3'b001: begin
        result   = a - b;
        overflow = (a[7] != b[7]) && (result[7] != a[7]);
      end
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = a ^ b;
      3'b101:  result = a << b[2:0];
      3'b110:  result = a >> b[2:0];
      default: result = 8'h00;
    endcase
  end

  assign zero = (result == 8'h00);
endmodule

module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req_a0,
  input  logic [7:0]       req_b0,
  input  logic [2:0]       req_op0,
  input  logic [7:0]       req_a1,
  input  logic [7:0]       req_b1,
  input  logic [2:0]       req_op1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nx;
  logic       last_served;
  logic       grant;
  logic       accept;
  logic [7:0] op_a, op_b;
  logic [2:0] op_code;
  logic       op_id;
  logic [7:0] alu_result;
  logic       alu_zero, alu_overflow;

  alu u_alu (
    .a        (op_a),
    .b        (op_b),
    .op       (op_code),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  // On a tie the requester not served last wins; otherwise whoever is valid.
  always_comb begin
    if (req_valid == 2'b11) grant = ~last_served;
    else                    grant = req_valid[1];
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && req_valid[grant]) req_ready[grant] = 1'b1;
  end

  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a         <= 8'h00;
      op_b         <= 8'h00;
      op_code      <= 3'b000;
      op_id        <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 8'h00;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
      last_served  <= 1'b1;
      ops_count    <= '0;
    end else begin
      if (state == IDLE && accept) begin
        op_a    <= grant ? req_a1  : req_a0;
        op_b    <= grant ? req_b1  : req_b0;
        op_code <= grant ? req_op1 : req_op0;
        op_id   <= grant;
      end
      if (state == EXEC) begin
        rsp_id <= op_id;
        if (op_code == 3'b111) begin
          rsp_result   <= 8'h00;
          rsp_zero     <= 1'b0;
          rsp_overflow <= 1'b0;
          rsp_err      <= 1'b1;
        end else begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow;
          rsp_err      <= 1'b0;
        end
      end
      // Fairness pointer moves on completion, not on accept.
      if (state == RESP && rsp_ready) begin
        last_served <= rsp_id;
        if (ops_count != {CNT_W{1'b1}}) ops_count <= ops_count + 1'b1;
      end
    end
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin controller that shares one 8-bit `alu` instance between two independent requesters. It accepts one operation at a time through a valid/ready request handshake and holds the registered result until a shared valid/ready response handshake completes; the response carries the requester ID. The block sits between the two operand-issuing front-ends and the combinational ALU. It is the only block that drives the ALU's `a`, `b` and `op` inputs.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester accept; at most one bit high.
- `req_a0`, `req_b0`  in  8 each  requester 0 operands.
- `req_op0`  in  3  requester 0 opcode.
- `req_a1`, `req_b1`  in  8 each  requester 1 operands.
- `req_op1`  in  3  requester 1 opcode.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  1  requester that issued the returned operation.
- `rsp_result`  out  8  ALU result.
- `rsp_zero`  out  1  ALU zero flag.
- `rsp_overflow`  out  1  ALU overflow flag.
- `rsp_err`  out  1  set when the opcode was illegal.
- `busy`  out  1  high whenever state is not IDLE.
- `ops_count`  out  CNT_W  completed responses; saturates at all-ones.

## Operation
- Opcodes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shift left, 110 shift right. Opcode 111 is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the requester not served last when both are valid, otherwise to the single valid one.
  - `req_ready[grant]` is driven combinationally high only in IDLE and only for a valid requester.
  - On `req_valid[i] && req_ready[i]`: latch a/b/op/id into operand registers and go to EXEC.
- EXEC:
  - The internal `alu` is driven from the operand registers.
  - `result`, `zero` and `overflow` are registered into the rsp_* registers, and `rsp_err` is cleared.
  - For op 111 the ALU output is ignored: `rsp_result`=0, `rsp_zero`=0, `rsp_overflow`=0, `rsp_err`=1.
  - Next state is RESP.
- RESP:
  - `rsp_valid`=1, and all rsp_* outputs are held stable.
  - On `rsp_ready`: update the last-served pointer to `rsp_id`, increment `ops_count` (saturating), and return to IDLE.
- Requesters must hold `req_valid` and operands stable until accepted. A dropped `req_valid` before acceptance simply withdraws the request.
- The last-served pointer updates only on response completion, not on accept.

## Timing
- Reset values: state=IDLE, `req_ready`=00, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0x00, `rsp_zero`=0, `rsp_overflow`=0, `rsp_err`=0, `busy`=0, `ops_count`=0. The last-served pointer resets to 1, so requester 0 wins the first tie.
- Cycle sequence for one operation:
  - Accept in cycle C.
  - EXEC in C+1.
  - `rsp_valid` high from C+2.
  - With `rsp_ready` high in C+2, IDLE in C+3 and the next accept is possible in C+3.
- Latency: 2 cycles from accept to `rsp_valid`. Minimum issue interval is 3 cycles.
- Backpressure: RESP persists indefinitely while `rsp_ready`=0. No new request is accepted meanwhile; `req_ready`=00.
- `rsp_ready` outside RESP has no effect.
- Reset asserted mid-operation, in any state, drops the pending operation with no response. All outputs return to reset values immediately (asynchronous reset).
- `ops_count` at all-ones stays at all-ones.

## Test plan
- Single add: req0 a=0x25 b=0x1A op=000, `rsp_ready`=1 -> `req_ready`=01 in accept cycle. Two cycles later `rsp_valid`=1, id=0, result=0x3F, zero=0, overflow=0, err=0. `ops_count`=1.
- Contention: both valid continuously; req0 op=010 a=0xAA b=0xCC, req1 op=100 a=0xAA b=0xCC -> responses alternate: id0 0x88, id1 0x66, id0 0x88, and so on, one every 3 cycles.
- Overflow and zero: req1 a=0x80 b=0x01 op=001 -> result=0x7F, overflow=1. Then a=0x00 b=0x00 op=000 -> result=0x00, zero=1.
- Illegal op: req0 op=111 a=0xFF b=0xFF -> `rsp_err`=1, result=0x00, zero=0, overflow=0. The counter still increments.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` -> outputs stable, `req_ready`=00 despite req1 valid, and req1 is accepted in the cycle after the response handshake.
- Reset mid-op: pull `rst_n` low during EXEC -> `rsp_valid`=0 and `busy`=0 immediately. After release, no stale response appears, and requester 0 wins the first tie.
